// File: rtl/ysyx_22040895_mem_arbiter.sv
// Two-master (IFU/LSU) single-outstanding memory arbiter with WAIT timeout.
// Optional round-robin arbitration: define YSYX_22040895_ARB_RR_EN (otherwise LSU has fixed priority).
//
// state | meaning
// IDLE  | no transaction; grant a requester and capture its fields
// REQ   | mem_req_o asserted with captured fields until mem_ready_i
// WAIT  | waiting for mem_rvalid_i or the timeout
module ysyx_22040895_mem_arbiter #(
  parameter int AW  = 64,
  parameter int DW  = 64,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_err_o,
  input  logic          ls_req_i,
  input  logic          ls_we_i,
  input  logic [AW-1:0] ls_addr_i,
  input  logic [DW-1:0] ls_wdata_i,
  input  logic [7:0]    ls_wmask_i,
  output logic          ls_gnt_o,
  output logic          ls_rvalid_o,
  output logic [DW-1:0] ls_rdata_o,
  output logic          ls_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [7:0]    mem_wmask_o,
  input  logic          mem_ready_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t        state;
  state_t        state_nxt;
  logic          owner;      // 1 = LSU
  logic [7:0]    cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [7:0]    wmask_q;
  logic          we_q;
  logic          pick_ls;
  logic          any_req;
  logic          resp_hit;
  logic          tmo_hit;

`ifdef YSYX_22040895_ARB_RR_EN
  logic last_owner;
  // On contention, favour whoever was not granted most recently.
  assign pick_ls = ls_req_i && (!if_req_i || !last_owner);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= 1'b0;
    end else if (state == S_IDLE && any_req) begin
      last_owner <= pick_ls;
    end
  end
`else
  assign pick_ls = ls_req_i;
`endif

  assign any_req     = if_req_i || ls_req_i;
  assign mem_req_o   = (state == S_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;

  always_comb begin
    state_nxt = state;
    if_gnt_o  = 1'b0;
    ls_gnt_o  = 1'b0;
    resp_hit  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        // gnt is combinational, so gate it while reset is asserted
        if (any_req && rst) begin
          ls_gnt_o  = pick_ls;
          if_gnt_o  = !pick_ls;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready_i) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          resp_hit  = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      cnt     <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= 8'd0;
      we_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any_req) begin
        owner   <= pick_ls;
        addr_q  <= pick_ls ? ls_addr_i : if_addr_i;
        wdata_q <= pick_ls ? ls_wdata_i : '0;
        wmask_q <= pick_ls ? ls_wmask_i : 8'hFF;
        we_q    <= pick_ls && ls_we_i;
      end
      if (state == S_REQ) begin
        cnt <= 8'd0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid_o <= 1'b0;
      if_err_o    <= 1'b0;
      if_rdata_o  <= '0;
      ls_rvalid_o <= 1'b0;
      ls_err_o    <= 1'b0;
      ls_rdata_o  <= '0;
    end else begin
      if_rvalid_o <= (resp_hit || tmo_hit) && !owner;
      if_err_o    <= tmo_hit && !owner;
      ls_rvalid_o <= (resp_hit || tmo_hit) && owner;
      ls_err_o    <= tmo_hit && owner;
      // Timeout returns zero data; rdata otherwise holds between pulses.
      if ((resp_hit || tmo_hit) && !owner) if_rdata_o <= resp_hit ? mem_rdata_i : '0;
      if ((resp_hit || tmo_hit) && owner) ls_rdata_o <= resp_hit ? mem_rdata_i : '0;
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_mem_arbiter.sv
// Scoreboard bench for ysyx_22040895_mem_arbiter: stimulus pushes expected grants and
// responses, a negedge monitor pops and compares. Honors YSYX_22040895_ARB_RR_EN.
module tb_ysyx_22040895_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic [63:0] if_rdata_o;
  logic        ls_req, ls_we;
  logic [63:0] ls_addr, ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [63:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;

  ysyx_22040895_mem_arbiter #(.AW(64), .DW(64), .TMO(255)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_wmask_i(ls_wmask), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ls;
    logic [63:0] data;
    bit          err;
  } resp_t;

  resp_t resp_q[$];
  bit    gnt_q[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Monitor: every grant and every response pulse is matched against the queues.
  always @(negedge clk) begin
    bit    e;
    resp_t r;
    if (rst) begin
      if (if_gnt_o || ls_gnt_o) begin
        if (gnt_q.size() == 0) check("unexpected_gnt", {62'd0, if_gnt_o, ls_gnt_o}, 64'd0);
        else begin
          e = gnt_q.pop_front();
          check("gnt_ls", ls_gnt_o, e);
          check("gnt_if", if_gnt_o, !e);
        end
      end
      if (if_rvalid_o || ls_rvalid_o) begin
        if (resp_q.size() == 0) check("unexpected_rvalid", {62'd0, if_rvalid_o, ls_rvalid_o}, 64'd0);
        else begin
          r = resp_q.pop_front();
          check("rvalid_ls", ls_rvalid_o, r.ls);
          check("rvalid_if", if_rvalid_o, !r.ls);
          check("rdata", r.ls ? ls_rdata_o : if_rdata_o, r.data);
          check("err", r.ls ? ls_err_o : if_err_o, r.err);
          check("other_err", r.ls ? if_err_o : ls_err_o, 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_ctl"}, {56'd0, if_gnt_o, if_rvalid_o, if_err_o, ls_gnt_o,
                          ls_rvalid_o, ls_err_o, mem_req_o, mem_we_o}, 64'd0);
    check({tag, "_if_rdata"}, if_rdata_o, 64'd0);
    check({tag, "_ls_rdata"}, ls_rdata_o, 64'd0);
    check({tag, "_mem_addr"}, mem_addr_o, 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 64'd0);
    check({tag, "_mem_wmask"}, {56'd0, mem_wmask_o}, 64'd0);
  endtask

  task automatic check_mem(logic [63:0] addr, logic [63:0] wdata, logic [7:0] wmask, bit we);
    check("mem_req", mem_req_o, 1);
    check("mem_addr", mem_addr_o, addr);
    check("mem_wdata", mem_wdata_o, wdata);
    check("mem_wmask", {56'd0, mem_wmask_o}, {56'd0, wmask});
    check("mem_we", mem_we_o, we);
  endtask

  // hold: 0 = drop own request after grant, 1 = keep requesting, 2 = drop both requests
  task automatic txn(input bit ls, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wmask, input int ready_dly, input bit noise,
                     input int resp_dly, input bit respond, input logic [63:0] rdata,
                     input int hold);
    logic [63:0] e_wdata;
    logic [7:0]  e_mask;
    bit          e_we;
    bit          got;
    int          n;
    resp_t       r;
    e_wdata = ls ? wdata : 64'd0;
    e_mask  = ls ? wmask : 8'hFF;
    e_we    = ls && we;
    r.ls    = ls;
    r.data  = respond ? rdata : 64'd0;
    r.err   = !respond;
    gnt_q.push_back(ls);
    resp_q.push_back(r);
    if (ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_wmask = wmask;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = ls ? ls_gnt_o : if_gnt_o;
    end
    check("gnt_seen", got, 1);
    check("mem_req_at_gnt", mem_req_o, 0);
    step();
    if (hold == 0) begin
      if (ls) ls_req = 1'b0; else if_req = 1'b0;
    end else if (hold == 2) begin
      ls_req = 1'b0; if_req = 1'b0;
    end
    for (int i = 0; i < ready_dly; i++) begin
      mem_rvalid = noise;
      mem_rdata  = 64'hDEAD;
      @(negedge clk);
      check_mem(addr, e_wdata, e_mask, e_we);
      step();
    end
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    @(negedge clk);
    check_mem(addr, e_wdata, e_mask, e_we);
    step();
    mem_ready = 1'b0;
    if (respond) begin
      repeat (resp_dly) step();
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      step();
      mem_rvalid = 1'b0;
    end else begin
      n = 0;
      got = 1'b0;
      while (!got && n < 300) begin
        @(negedge clk);
        n++;
        got = if_rvalid_o || ls_rvalid_o;
      end
      check("timeout_cycles", n, 256);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) step();
    check_zero_outputs("reset");
    rst = 1'b1;
    step();

    // IFU read, ready at once, rvalid two cycles after ready
    txn(0, 0, 64'h8000_0000, 64'h0, 8'h0, 0, 0, 1, 1, 64'h1234, 0);
    step();
    @(negedge clk);
    check("if_rdata_hold", if_rdata_o, 64'h1234);
    check("if_rvalid_single", if_rvalid_o, 0);
    check("ls_rvalid_idle", ls_rvalid_o, 0);
    step();

    // LSU byte write, ready held off 5 cycles with spurious rvalid during REQ
    txn(1, 1, 64'h100, 64'hAB, 8'h01, 5, 1, 0, 1, 64'h5A, 0);
    step();
    // response in the first WAIT cycle
    txn(0, 0, 64'h8000_0008, 64'h0, 8'h0, 0, 0, 0, 1, 64'hCAFE, 0);
    step();
    // response in the same cycle the counter reaches the limit: normal, no error
    txn(0, 0, 64'h8000_0010, 64'h0, 8'h0, 0, 0, 254, 1, 64'hBEEF, 0);
    step();
    // no response at all: timeout with err and zero data
    txn(0, 0, 64'h8000_0018, 64'h0, 8'h0, 0, 0, 0, 0, 64'h0, 0);
    step();
    @(negedge clk);
    check("if_rdata_after_tmo", if_rdata_o, 64'h0);
    step();

    // reset in WAIT, then a late mem_rvalid_i must be ignored
    gnt_q.push_back(0);
    if_req = 1'b1; if_addr = 64'h2000;
    @(negedge clk);
    check("rst_case_gnt", if_gnt_o, 1);
    step();
    if_req = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check_zero_outputs("rst_in_wait");
    step();
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h77;
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("late_rvalid_ignored", {62'd0, if_rvalid_o, ls_rvalid_o}, 64'd0);
    step();
    @(negedge clk);
    check("late_rvalid_ignored2", {62'd0, if_rvalid_o, ls_rvalid_o}, 64'd0);
    step();
    txn(0, 0, 64'h3000, 64'h0, 8'h0, 0, 0, 1, 1, 64'h99, 0);
    step();

    // contention, starting from reset so the last-served owner is IFU
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    if_req = 1'b1; if_addr = 64'h4000;
`ifdef YSYX_22040895_ARB_RR_EN
    txn(1, 0, 64'h500, 64'h0, 8'hFF, 0, 0, 0, 1, 64'h11, 1);
    txn(0, 0, 64'h4000, 64'h0, 8'h0, 0, 0, 0, 1, 64'h22, 1);
    txn(1, 0, 64'h508, 64'h0, 8'hFF, 0, 0, 0, 1, 64'h33, 1);
    txn(0, 0, 64'h4000, 64'h0, 8'h0, 0, 0, 0, 1, 64'h44, 2);
`else
    txn(1, 0, 64'h500, 64'h0, 8'hFF, 0, 0, 0, 1, 64'h11, 1);
    txn(1, 0, 64'h508, 64'h0, 8'hFF, 0, 0, 0, 1, 64'h22, 1);
    txn(1, 0, 64'h510, 64'h0, 8'hFF, 0, 0, 0, 1, 64'h33, 0);
    txn(0, 0, 64'h4000, 64'h0, 8'h0, 0, 0, 0, 1, 64'h44, 0);
`endif
    repeat (3) step();
    check("gnt_q_drained", gnt_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
